// File: rtl/pwm_dac_if.sv
// Handshake and data bundle for pwm_dac.
// Parameters: N (code width), VW (vout_mv width), PCW (period_cnt width).
// Signals:
//   start, din        controller -> DAC (start is sampled only while IDLE)
//   pwm_out           registered PWM output
//   vout_mv           ideal output voltage in mV for the latched code
//   busy, eoc         conversion running / one-cycle completion pulse
//   period_cnt        completed PWM periods in the current run
// Handshake: start is a request that is accepted on a rising clock edge
// only while the DAC is idle (busy=0 and eoc=0). An accepted start raises
// busy on the next cycle. Completion is a single-cycle eoc pulse with busy
// low. A start seen while busy or during eoc is dropped, not queued.
interface pwm_dac_if #(
  parameter int N   = 10,
  parameter int VW  = 16,
  parameter int PCW = 1
);
  logic           start;
  logic [N-1:0]   din;
  logic           pwm_out;
  logic [VW-1:0]  vout_mv;
  logic           busy;
  logic           eoc;
  logic [PCW-1:0] period_cnt;

  modport master (
    output start, din,
    input  pwm_out, vout_mv, busy, eoc, period_cnt
  );

  modport slave (
    input  start, din,
    output pwm_out, vout_mv, busy, eoc, period_cnt
  );
endinterface

// File: rtl/pwm_dac.sv
// PWM DAC: turns an N-bit code into a PWM waveform with duty code/2^N,
// repeated for PERIODS periods per start, and reports the ideal output
// voltage code*reso in mV.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   bus        pwm_dac_if slave modport (start/din in; pwm_out, vout_mv,
//              busy, eoc, period_cnt out)
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
module pwm_dac #(
  parameter int N       = 10,
  parameter int VREF    = 5000,
  parameter int PERIODS = 1,
  parameter int VW      = 16,
  localparam int PCW    = $clog2(PERIODS + 1)
) (
  input  logic        clk,
  input  logic        reset,
  pwm_dac_if.slave    bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int             RESO     = VREF / (1 << N);
  localparam logic [N-1:0]   CNT_MAX  = {N{1'b1}};
  localparam logic [PCW-1:0] PER_LAST = PCW'(PERIODS);

  state_e         state_q, state_d;
  logic [N-1:0]   code_q, code_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [PCW-1:0] period_q, period_d;
  logic           pwm_q, pwm_d;
  logic [VW-1:0]  vout_q, vout_d;

  logic [N+31:0]  prod;
  logic [N-1:0]   cnt_inc;
  logic [PCW-1:0] period_inc;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    pwm_d      = pwm_q;
    vout_d     = vout_q;
    prod       = (N+32)'(bus.din) * (N+32)'(RESO);
    cnt_inc    = cnt_q + 1'b1;
    period_inc = period_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          code_d   = bus.din;
          vout_d   = prod[VW-1:0];
          cnt_d    = '0;
          period_d = '0;
          // pwm_out is registered alongside cnt, so the first RUN cycle
          // (cnt=0) already shows 0 < din.
          pwm_d    = (bus.din != '0);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        pwm_d = (cnt_inc < code_q);
        if (cnt_q == CNT_MAX) begin
          period_d = period_inc;
          if (period_inc == PER_LAST) begin
            pwm_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        pwm_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        pwm_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      pwm_q    <= 1'b0;
      vout_q   <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pwm_q    <= pwm_d;
      vout_q   <= vout_d;
    end
  end

  // busy and eoc decode straight from the state register, so they can
  // never be high together.
  assign bus.pwm_out    = pwm_q;
  assign bus.vout_mv    = vout_q;
  assign bus.busy       = (state_q == S_RUN);
  assign bus.eoc        = (state_q == S_DONE);
  assign bus.period_cnt = period_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_pwm_dac.sv
module tb_pwm_dac;

  logic       clk;
  logic       reset;
  logic [1:0] dbg1;
  logic [1:0] dbg3;

  int total = 0;
  int bad   = 0;

  // Expected entry: {vout_mv[15:0], high clocks[15:0], busy clocks[15:0]}
  logic [47:0] exp1_q[$];
  logic [47:0] exp3_q[$];

  int hi1, len1, hi3, len3;

  pwm_dac_if #(.N(10), .VW(16), .PCW(1)) if1 ();
  pwm_dac_if #(.N(10), .VW(16), .PCW(2)) if3 ();

  pwm_dac #(.N(10), .VREF(5000), .PERIODS(1), .VW(16)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (if1.slave),
    .dbg_state (dbg1)
  );

  pwm_dac #(.N(10), .VREF(5000), .PERIODS(3), .VW(16)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .bus       (if3.slave),
    .dbg_state (dbg3)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk_exp(input int code, input int periods);
    logic [15:0] v, h, l;
    v = 16'((code * 5000) / 1024 - ((code * 5000) / 1024 - code * (5000 / 1024)));
    h = 16'(code * periods);
    l = 16'(1024 * periods);
    return {v, h, l};
  endfunction

  // monitor + scoreboard, PERIODS=1 instance
  always @(negedge clk) begin
    logic [47:0] e;
    if (!reset) begin
      hi1  = 0;
      len1 = 0;
    end else begin
      chk("busy_eoc_1", 32'(if1.busy & if1.eoc), 32'd0);
      if (if1.busy) begin
        len1++;
        if (if1.pwm_out) hi1++;
      end else begin
        chk("pwm_idle_1", 32'(if1.pwm_out), 32'd0);
      end
      if (if1.eoc) begin
        if (exp1_q.size() == 0) begin
          chk("eoc_unexp_1", 32'd1, 32'd0);
        end else begin
          e = exp1_q.pop_front();
          chk("vout_1", 32'(if1.vout_mv), 32'(e[47:32]));
          chk("high_1", 32'(hi1), 32'(e[31:16]));
          chk("len_1", 32'(len1), 32'(e[15:0]));
          chk("pcnt_end_1", 32'(if1.period_cnt), 32'd1);
        end
        hi1  = 0;
        len1 = 0;
      end
    end
  end

  // monitor + scoreboard, PERIODS=3 instance
  always @(negedge clk) begin
    logic [47:0] e;
    if (!reset) begin
      hi3  = 0;
      len3 = 0;
    end else begin
      chk("busy_eoc_3", 32'(if3.busy & if3.eoc), 32'd0);
      if (if3.busy) begin
        len3++;
        if (if3.pwm_out) hi3++;
        if ((len3 % 1024) == 1)
          chk("pcnt_step_3", 32'(if3.period_cnt), 32'((len3 - 1) / 1024));
      end else begin
        chk("pwm_idle_3", 32'(if3.pwm_out), 32'd0);
      end
      if (if3.eoc) begin
        if (exp3_q.size() == 0) begin
          chk("eoc_unexp_3", 32'd1, 32'd0);
        end else begin
          e = exp3_q.pop_front();
          chk("vout_3", 32'(if3.vout_mv), 32'(e[47:32]));
          chk("high_3", 32'(hi3), 32'(e[31:16]));
          chk("len_3", 32'(len3), 32'(e[15:0]));
          chk("pcnt_end_3", 32'(if3.period_cnt), 32'd3);
        end
        hi3  = 0;
        len3 = 0;
      end
    end
  end

  // driver tasks
  task automatic wait_idle1();
    int n = 0;
    @(negedge clk);
    while ((if1.busy || if1.eoc) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout_1", 32'(n >= 5000), 32'd0);
  endtask

  task automatic wait_idle3();
    int n = 0;
    @(negedge clk);
    while ((if3.busy || if3.eoc) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout_3", 32'(n >= 5000), 32'd0);
  endtask

  task automatic run_conv1(input int code);
    logic [47:0] e;
    wait_idle1();
    e = mk_exp(code, 1);
    exp1_q.push_back(e);
    if1.din   = 10'(code);
    if1.start = 1'b1;
    @(posedge clk);
    #1;
    if1.start = 1'b0;
    if1.din   = 10'($urandom_range(0, 1023));
    @(negedge clk);
    chk("busy_rise_1", 32'(if1.busy), 32'd1);
    chk("vout_latch_1", 32'(if1.vout_mv), 32'(e[47:32]));
  endtask

  initial begin : stim
    int codes[5];
    int n;
    codes[0] = 0;
    codes[1] = 1;
    codes[2] = 512;
    codes[3] = 1023;
    codes[4] = $urandom_range(2, 1022);

    reset     = 1'b0;
    if1.start = 1'b0;
    if1.din   = '0;
    if3.start = 1'b0;
    if3.din   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(if1.busy), 32'd0);
    chk("rst_eoc", 32'(if1.eoc), 32'd0);
    chk("rst_pwm", 32'(if1.pwm_out), 32'd0);
    chk("rst_vout", 32'(if1.vout_mv), 32'd0);
    chk("rst_pcnt", 32'(if1.period_cnt), 32'd0);
    chk("rst_state", 32'(dbg1), 32'd0);
    reset = 1'b1;

    // idle, no start
    repeat (20) begin
      @(negedge clk);
      chk("idle_busy", 32'(if1.busy), 32'd0);
      chk("idle_vout", 32'(if1.vout_mv), 32'd0);
    end

    // basic conversion and code sweep
    run_conv1(1000);
    foreach (codes[i]) run_conv1(codes[i]);
    wait_idle1();

    // three periods on the second instance
    wait_idle3();
    exp3_q.push_back(mk_exp(674, 3));
    if3.din   = 10'd674;
    if3.start = 1'b1;
    @(posedge clk);
    #1;
    if3.start = 1'b0;
    if3.din   = 10'd5;
    @(negedge clk);
    chk("busy_rise_3", 32'(if3.busy), 32'd1);
    wait_idle3();

    // start and din change mid-run are ignored
    run_conv1(200);
    repeat (100) @(negedge clk);
    if1.din   = 10'd900;
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    wait_idle1();
    repeat (4) @(negedge clk);

    // start held high: back-to-back conversions
    exp1_q.push_back(mk_exp(300, 1));
    exp1_q.push_back(mk_exp(300, 1));
    if1.din   = 10'd300;
    if1.start = 1'b1;
    @(negedge clk);
    chk("b2b_first", 32'(if1.busy), 32'd1);
    n = 0;
    while (!if1.eoc && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_timeout", 32'(n >= 2000), 32'd0);
    @(negedge clk);
    chk("b2b_gap", 32'(if1.busy), 32'd0);
    @(negedge clk);
    chk("b2b_rise", 32'(if1.busy), 32'd1);
    if1.start = 1'b0;
    wait_idle1();

    // reset mid-run at cnt=300
    run_conv1(500);
    repeat (300) @(negedge clk);
    chk("pre_rst_pwm", 32'(if1.pwm_out), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(if1.busy), 32'd0);
    chk("abort_eoc", 32'(if1.eoc), 32'd0);
    chk("abort_pwm", 32'(if1.pwm_out), 32'd0);
    chk("abort_vout", 32'(if1.vout_mv), 32'd0);
    chk("abort_pcnt", 32'(if1.period_cnt), 32'd0);
    exp1_q.delete();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_conv1(77);
    wait_idle1();
    repeat (3) @(negedge clk);

    chk("drain_1", 32'(exp1_q.size()), 32'd0);
    chk("drain_3", 32'(exp3_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
